// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, the stage sequencer state type and the
// stage output mux encodings.
package fft_pkg;

    localparam int unsigned FFT_NUM   = 16;
    localparam int unsigned FFT_DATA  = 512;
    localparam int unsigned FFT_COUNT = FFT_DATA / FFT_NUM;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CALC,
        DRAIN
    } bfly_state_e;

    localparam logic SEL_SUM = 1'b0;
    localparam logic SEL_SR  = 1'b1;

endpackage

// File: rtl/valid_pipe.sv
// Fixed-latency valid delay that tracks the butterfly register latency.
// Synchronous clear drops every beat in flight.
module valid_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe <= '0;
        end else if (clear) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[LAT-1];

endmodule

// File: rtl/bfly_stage_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: fill / calculate / drain schedule,
// delay-line and butterfly strobes, twiddle addressing and upstream throttling.
module bfly_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned NUM      = FFT_NUM,
    parameter int unsigned DATA     = FFT_DATA,
    parameter int unsigned COUNT    = DATA / NUM,
    parameter int unsigned HALF     = COUNT / 2,
    parameter int unsigned BFLY_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_in,
    input  logic                    clear,
    output logic                    in_ready,
    output logic                    sr_shift,
    output logic                    sr_wsel,
    output logic                    bfly_en,
    output logic                    out_sel,
    output logic [$clog2(HALF)-1:0] tw_addr,
    output logic                    valid_out,
    output logic                    frame_done,
    output logic                    ovf
);

    localparam int unsigned BEAT_W = $clog2(COUNT);
    localparam int unsigned DCNT_W = $clog2(HALF);

    localparam logic [BEAT_W-1:0] FILL_LAST  = BEAT_W'(HALF - 1);
    localparam logic [BEAT_W-1:0] CALC_LAST  = BEAT_W'(COUNT - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(HALF - 1);

    bfly_state_e       state;
    logic [BEAT_W-1:0] beat;
    logic [DCNT_W-1:0] dcnt;
    logic              accept;
    logic              pipe_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            beat  <= '0;
            dcnt  <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            beat  <= '0;
            dcnt  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (valid_in && !in_ready) begin
                ovf <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    // The accepted beat is FILL beat 0, so counting resumes at 1.
                    if (valid_in) begin
                        state <= FILL;
                        beat  <= BEAT_W'(1);
                    end
                end
                FILL: begin
                    if (valid_in) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat == FILL_LAST) begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (valid_in) begin
                        if (beat == CALC_LAST) begin
                            state <= DRAIN;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == DRAIN_LAST) begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state != DRAIN);
        accept     = valid_in & in_ready & ~clear;
        sr_shift   = 1'b0;
        sr_wsel    = 1'b0;
        bfly_en    = 1'b0;
        out_sel    = SEL_SUM;
        tw_addr    = '0;
        frame_done = 1'b0;
        pipe_in    = 1'b0;
        unique case (state)
            IDLE, FILL: begin
                sr_shift = accept;
            end
            CALC: begin
                if (accept) begin
                    bfly_en  = 1'b1;
                    sr_shift = 1'b1;
                    sr_wsel  = 1'b1;
                    pipe_in  = 1'b1;
                end
            end
            DRAIN: begin
                sr_shift   = 1'b1;
                out_sel    = SEL_SR;
                tw_addr    = dcnt;
                pipe_in    = 1'b1;
                frame_done = (dcnt == DRAIN_LAST);
            end
            default: ;
        endcase
    end

    valid_pipe #(
        .LAT (BFLY_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .clear (clear),
        .din   (pipe_in),
        .dout  (valid_out)
    );

endmodule

// File: doc/bfly_stage_ctrl.md
# bfly_stage_ctrl

Sequencer for one radix-2 single-delay-feedback FFT butterfly stage. It owns the beat counter and the three-phase frame schedule (fill, calculate, drain). It drives the delay-line shift/write-select, the butterfly enable, the output mux select and the twiddle address, and it throttles upstream with `in_ready`. One instance sits beside each stage's butterfly and delay line; stages are chained through `valid_out` → `valid_in`.

## Interface
- `NUM`, 16: parallel lines per beat.
- `DATA`, 512: samples per frame.
- `COUNT`, `DATA/NUM`: beats per frame; must be even and ≥ 4.
- `HALF`, `COUNT/2`: delay-line depth in beats.
- `BFLY_LAT`, 1: butterfly register latency in cycles; allowed range 1–4.

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  input beat present; accepted only when `valid_in & in_ready`.
- `clear`  in  1  synchronous abort: return to IDLE and clear `ovf`.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `sr_shift`  out  1  delay line advances one beat.
- `sr_wsel`  out  1  delay-line write source: 0 = raw input, 1 = butterfly difference.
- `bfly_en`  out  1  butterfly computes this cycle.
- `out_sel`  out  1  stage output mux: 0 = butterfly sum, 1 = delay-line output.
- `tw_addr`  out  `$clog2(HALF)`  twiddle ROM index for the current drain beat.
- `valid_out`  out  1  stage output beat valid.
- `frame_done`  out  1  single-cycle pulse on the last drain beat.
- `ovf`  out  1  sticky flag: `valid_in` was high while `in_ready` was low.

## Operation
- States and actions:
  - IDLE: `in_ready`=1. An accepted beat goes to FILL with `beat`=1 and performs the FILL actions for beat 0.
  - FILL (`beat` 0..HALF-1): `sr_shift`=1 and `sr_wsel`=0 on each accepted beat only. Accepted beat HALF-1 goes to CALC.
  - CALC (`beat` HALF..COUNT-1): on each accepted beat, `bfly_en`=1, `sr_shift`=1, `sr_wsel`=1, `out_sel`=0, and one valid sum beat is issued. Accepted beat COUNT-1 goes to DRAIN.
  - DRAIN (`dcnt` 0..HALF-1): `in_ready`=0. `sr_shift`=1, `out_sel`=1 and `tw_addr`=`dcnt` every cycle, with no dependence on `valid_in`. At `dcnt`=HALF-1, `frame_done`=1 and the next state is IDLE.
- Counters:
  - `beat` is a `$clog2(COUNT)`-bit counter and advances only on accepted beats.
  - `dcnt` is a `$clog2(HALF)`-bit counter and advances every DRAIN cycle.
  - Both counters are zero on entry to DRAIN and on entry to IDLE.
- In FILL and CALC, `in_ready`=1. A cycle with `valid_in`=0 holds all counters, and the strobes are 0.
- `tw_addr` is 0 outside DRAIN.
- `ovf` sets on `valid_in & ~in_ready` and holds until `clear` or reset. The offending beat is dropped.
- Simultaneous events:
  - `clear` and `valid_in` in the same cycle: `clear` wins and the beat is not accepted.
  - `ovf` set condition and `clear` in the same cycle: `clear` wins.

## Timing
- Reset values: state=IDLE, both counters=0, all outputs 0 except `in_ready`=1.
- Strobes `sr_shift`, `sr_wsel`, `bfly_en`, `out_sel` and `tw_addr` are combinational from state, counters and `valid_in`.
- `valid_out` is a BFLY_LAT-deep delay pipe:
  - Input to the pipe: a CALC accepted beat, or any DRAIN cycle.
  - The pipe is cleared by reset and by `clear`.
- `frame_done` is aligned with the last drain strobe. It is not delayed by BFLY_LAT.
- Frame cycle count with no input bubbles: COUNT + HALF cycles. The minimum gap between frames is HALF cycles of `in_ready`=0.
- Reset or `clear` mid-frame: return to IDLE next cycle. Contents of the delay line are then don't-care.

## Structure
- Shared FFT package `fft_pkg` holds:
  - the state enum type `bfly_state_e` (IDLE, FILL, CALC, DRAIN);
  - constants `FFT_NUM`, `FFT_DATA`, `FFT_COUNT`;
  - the mux-select encodings `SEL_SUM`=0, `SEL_SR`=1.
- One sub-module, `valid_pipe`, implements the parameterised BFLY_LAT delay with synchronous clear.

## Test plan
- Defaults, continuous `valid_in` from IDLE:
  - cycles 0–15: `sr_wsel`=0;
  - cycles 16–31: `bfly_en`=1;
  - cycles 32–47: `out_sel`=1 with `tw_addr` 0..15;
  - `valid_out` high from cycle 17 through cycle 48;
  - `frame_done` at cycle 47;
  - `in_ready`=0 for cycles 32–47.
- Alternate-cycle `valid_in` in FILL/CALC: `beat` advances only on high cycles. CALC completes after 16 accepted beats (32 cycles). Strobes are 0 on bubble cycles.
- `valid_in` held high through DRAIN:
  - `ovf`=1 from the first drain cycle +1;
  - drain still lasts exactly 16 cycles;
  - the next frame starts in the cycle after IDLE is entered.
- `clear` at CALC `beat`=20, asserted together with `valid_in`: the next cycle is IDLE, `valid_out` is 0 the cycle after, `ovf` clears, and no beat is accepted.
- `rstn` pulsed low for 3 cycles mid-DRAIN: all outputs take their reset values immediately (asynchronously). A new frame then runs exactly as in the first scenario.
- `BFLY_LAT`=3: the `valid_out` window shifts to cycles 19–50, while `frame_done` remains at cycle 47.
